// File: rtl/reg_file_writeback.sv
// Architectural register file (r0-r14), PC (r15) and retired-instruction counter.
// Optional same-cycle write-through on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file_writeback #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [3:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic        linkEnable,
  input  logic        stall,
  input  logic [3:0]  readAddrA,
  input  logic [3:0]  readAddrB,
  output logic [31:0] readDataA,
  output logic [31:0] readDataB,
  output logic [31:0] pcOut,
  output logic [31:0] instrCount
);

  localparam int unsigned NUM_GPR = 15;

  logic [31:0] regs_q [NUM_GPR];
  logic [31:0] regs_d [NUM_GPR];
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic        write_gpr;
  logic        branch;
  logic [31:0] link_val;
  logic [31:0] stored_a, stored_b;

  assign write_gpr = writeEnable && (writeAddr != 4'hF);
  assign branch    = writeEnable && (writeAddr == 4'hF);
  assign link_val  = pc_q + PC_STEP;

  // Read-port select: r15 reads as PC+8; r0-r14 optionally see this cycle's write/link.
  function automatic logic [31:0] read_sel(
    input logic [3:0]  addr,
    input logic [31:0] stored,
    input logic [31:0] pc,
    input logic        we,
    input logic [3:0]  waddr,
    input logic [31:0] wdata,
    input logic        link,
    input logic [31:0] lval
  );
    logic [31:0] val;
    if (addr == 4'hF) begin
      val = pc + 32'd8;
    end else begin
      val = stored;
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == addr)) val = wdata;
      if (link && (addr == 4'hE)) val = lval;
`else
      if (we && link && (waddr == addr) && (wdata == lval)) val = stored;
`endif
    end
    return val;
  endfunction

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (readAddrA == 4'(i)) stored_a = regs_q[i];
      if (readAddrB == 4'(i)) stored_b = regs_q[i];
    end
  end

  assign readDataA = read_sel(readAddrA, stored_a, pc_q, writeEnable, writeAddr,
                              writeData, linkEnable, link_val);
  assign readDataB = read_sel(readAddrB, stored_b, pc_q, writeEnable, writeAddr,
                              writeData, linkEnable, link_val);

  // Next-state: link overrides a concurrent writeback to r14.
  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) begin
      regs_d[i] = regs_q[i];
      if (write_gpr && (writeAddr == 4'(i))) regs_d[i] = writeData;
    end
    if (linkEnable) regs_d[14] = link_val;

    if (branch) begin
      pc_d = {writeData[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_STEP;
    end

    cnt_d = stall ? cnt_q : cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= '0;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= regs_d[i];
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pcOut      = pc_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_reg_file_writeback.sv
// Directed bench for reg_file_writeback: reset, increment, writes, branch/link, stall, reset, wrap.
module tb_reg_file_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [3:0]  writeAddr;
  logic [31:0] writeData;
  logic        linkEnable;
  logic        stall;
  logic [3:0]  readAddrA, readAddrB;
  logic [31:0] readDataA, readDataB, pcOut, instrCount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_writeback #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .linkEnable(linkEnable), .stall(stall),
    .readAddrA(readAddrA), .readAddrB(readAddrB),
    .readDataA(readDataA), .readDataB(readDataB),
    .pcOut(pcOut), .instrCount(instrCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEnable = 1'b0;
    writeAddr   = 4'h0;
    writeData   = 32'h0;
    linkEnable  = 1'b0;
    stall       = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    readAddrA = 4'hF;
    readAddrB = 4'h0;
    idle();

    step(); step();
    check("rst_pc", pcOut, 32'h0);
    check("rst_cnt", instrCount, 32'h0);
    check("rst_r15", readDataA, 32'h8);
    check("rst_r0", readDataB, 32'h0);

    reset = 1'b0;
    step();
    check("inc_pc1", pcOut, 32'h4);
    check("inc_cnt1", instrCount, 32'd1);
    step();
    check("inc_pc2", pcOut, 32'h8);
    step();
    check("inc_pc3", pcOut, 32'hC);
    check("inc_cnt3", instrCount, 32'd3);
    check("inc_r15", readDataA, 32'h14);

    // write r3 at pc=0xC
    readAddrA = 4'd3;
    writeEnable = 1'b1; writeAddr = 4'd3; writeData = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle", readDataA, 32'hDEAD_BEEF);
`else
    check("wr_same_cycle", readDataA, 32'h0);
`endif
    step();
    idle();
    #1;
    check("wr_next_cycle", readDataA, 32'hDEAD_BEEF);
    check("pc_0x10", pcOut, 32'h10);

    // branch with link at pc=0x10
    readAddrB = 4'd14;
    writeEnable = 1'b1; writeAddr = 4'hF; writeData = 32'h103; linkEnable = 1'b1;
    step();
    idle();
    #1;
    check("bl_pc", pcOut, 32'h100);
    check("bl_r14", readDataB, 32'h14);
    check("bl_cnt", instrCount, 32'd5);

    // branch to 0x20, then link collision
    writeEnable = 1'b1; writeAddr = 4'hF; writeData = 32'h20;
    step();
    check("br_pc_0x20", pcOut, 32'h20);
    writeEnable = 1'b1; writeAddr = 4'd14; writeData = 32'h55; linkEnable = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("coll_same_cycle", readDataB, 32'h24);
`else
    check("coll_same_cycle", readDataB, 32'h14);
`endif
    step();
    idle();
    #1;
    check("coll_r14", readDataB, 32'h24);

    // branch to 0x40, then stall three cycles with an r5 write
    writeEnable = 1'b1; writeAddr = 4'hF; writeData = 32'h40;
    step();
    check("br_pc_0x40", pcOut, 32'h40);
    check("pre_stall_cnt", instrCount, 32'd8);
    readAddrA = 4'd5;
    stall = 1'b1; writeEnable = 1'b1; writeAddr = 4'd5; writeData = 32'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pcOut, 32'h40);
      check("stall_cnt", instrCount, 32'd8);
    end
    check("stall_r5", readDataA, 32'd7);

    // branch during stall
    writeEnable = 1'b1; writeAddr = 4'hF; writeData = 32'h82;
    step();
    check("stall_br_pc", pcOut, 32'h80);
    check("stall_br_cnt", instrCount, 32'd8);
    idle();
    step();
    check("resume_pc", pcOut, 32'h84);
    check("resume_cnt", instrCount, 32'd9);

    // reset mid-operation discards the r2 write
    readAddrA = 4'd2;
    writeEnable = 1'b1; writeAddr = 4'd2; writeData = 32'd5;
    step();
    check("r2_pre", readDataA, 32'd5);
    reset = 1'b1;
    writeEnable = 1'b1; writeAddr = 4'd2; writeData = 32'd9; linkEnable = 1'b1;
    step();
    reset = 1'b0;
    idle();
    readAddrB = 4'd14;
    #1;
    check("rst_mid_r2", readDataA, 32'h0);
    check("rst_mid_r14", readDataB, 32'h0);
    check("rst_mid_pc", pcOut, 32'h0);
    check("rst_mid_cnt", instrCount, 32'h0);

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("wrap_pre", instrCount, 32'hFFFF_FFFF);
    step();
    check("wrap_cnt", instrCount, 32'h0);
    check("wrap_pc", pcOut, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_writeback.md
# reg_file_writeback

Architectural register file and program counter that consume the ALU output mux's `writebackEnable` and `aluMuxout` at the end of the single-cycle ARM datapath. It holds r0–r14 in flops, owns r15 as the PC, commits writebacks and branch targets on the clock edge, and provides two combinational read ports to decode. A retired-instruction counter provides lab debug visibility.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `PC_STEP`, 4, PC increment per non-stalled cycle.

Ports:
- `clk`  input  1  Single clock. All state updates on the rising edge.
- `reset`  input  1  Synchronous, active-high.
- `writeEnable`  input  1  Commit `writeData` to `writeAddr`. Driven from `writebackEnable`.
- `writeAddr`  input  4  Destination register, r0–r15.
- `writeData`  input  32  Writeback value. Driven from `aluMuxout`.
- `linkEnable`  input  1  Branch-with-link: write r14 with `pcOut + PC_STEP`.
- `stall`  input  1  Hold the PC and the counter. Register writes still commit.
- `readAddrA`, `readAddrB`  input  4  Read-port addresses.
- `readDataA`, `readDataB`  output  32  Combinational read data.
- `pcOut`  output  32  Current instruction address.
- `instrCount`  output  32  Count of retired (non-stalled) cycles since reset.

## Operation

- Storage: 15×32 array for r0–r14, plus a 32-bit PC register for r15.
- Reads are combinational:
  - Address 15 returns `pcOut + 8`, per ARM PC-read semantics.
  - Addresses 0–14 return the array entry, subject to bypass (see Configuration).
- Write to r0–r14 when `writeEnable`=1: the array entry takes `writeData` at the edge.
- Write to r15 when `writeEnable`=1 and `writeAddr`=15: branch.
  - PC <= `writeData` with bits [1:0] forced to 0.
  - Overrides both the increment and `stall`.
- Link when `linkEnable`=1: r14 <= `pcOut + PC_STEP`.
  - If the same cycle also has `writeEnable`=1 and `writeAddr`=14, link wins and `writeData` is discarded.
- PC next-state priority: reset > branch > stall (hold) > PC + `PC_STEP`.
- `instrCount` increments by 1 on every edge where `stall`=0 and reset is low.
  - A branch cycle counts as retired.
  - Wraps 32'hFFFF_FFFF -> 0 with no flag.
- Arithmetic is modulo 2^32; PC wraps silently.
- Reset, synchronous:
  - At a rising edge with `reset`=1: r0–r14 <= 0, PC <= `RESET_PC`, `instrCount` <= 0.
  - Reset dominates every concurrent write, link and stall.
  - Reset asserted mid-operation discards that cycle's write.
- Output values while/after reset: `pcOut`=`RESET_PC`, `instrCount`=0. `readDataA`/`readDataB` read 0 for r0–r14 and `RESET_PC + 8` for r15.

## Timing

- Read latency is 0 cycles (combinational from address and state).
- Write latency is 1 cycle: visible in the array after the rising edge.
- Branch: `pcOut` equals the target in the cycle after `writeEnable`/`writeAddr`=15 is sampled.
- Stall: while `stall`=1, `pcOut` and `instrCount` hold with no bound on duration.
- No handshake. Upstream guarantees `writeEnable` already includes condition-code qualification.

## Configuration

- Macro `REGFILE_BYPASS_EN`.
- Defined:
  - A read of r0–r14 whose address equals `writeAddr` while `writeEnable`=1 returns `writeData` in the same cycle (write-through).
  - If `linkEnable`=1 and the read address is 14, the read returns `pcOut + PC_STEP`.
  - No bypass for r15.
- Undefined: reads return the stored value only; the new value is visible the next cycle.

## Test plan

- Reset and increment, `RESET_PC`=0: hold `reset` 2 cycles, then run 3 cycles -> `pcOut` 0, 4, 8, 12; `instrCount` 0 -> 3; `readDataA`(r15) = `pcOut`+8.
- Write/read: write r3 = 32'hDEAD_BEEF -> `readDataA`(r3) = DEAD_BEEF next cycle. Same cycle returns DEAD_BEEF with `REGFILE_BYPASS_EN` defined, 0 without it.
- Branch with link at `pcOut`=0x10:
  - Stimulus: `writeEnable`=1, `writeAddr`=15, `writeData`=0x103, `linkEnable`=1.
  - Response: next `pcOut`=0x100, r14=0x14.
- Link collision: same cycle has `writeAddr`=14, `writeData`=0x55 and `linkEnable`=1 at `pcOut`=0x20 -> r14=0x24.
- Stall:
  - `stall`=1 for 3 cycles at `pcOut`=0x40 -> PC and count hold, while r5 write of 7 commits.
  - Branch to 0x80 during the stall -> next `pcOut`=0x80.
- Reset mid-operation:
  - Stimulus: `reset`=1 in the same cycle as a write to r2 = 9.
  - Response: r2=0, `pcOut`=`RESET_PC`.
  - Counter wrap: force count to FFFF_FFFF, one run cycle -> 0.
